four_track_sequencer: RTL

Score-reading front end that produces the four 6-bit note codes consumed by the four-track player. It fetches packed event words from a synchronous song ROM, updates per-track note registers, and times rests and holds in units of `TICK_DIV` cycles of `clk_128hz`. It supports one-shot and looping playback and can be stopped at any time.

---
 rtl/piano_pkg.sv | 32 +++
 rtl/four_track_sequencer_if.sv | 15 +
 rtl/tick_timer.sv | 51 +++++
 rtl/four_track_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared definitions for the piano score path: opcode values, event-word field
// positions, sequencer state encoding and the note width. The four-track player
// and the ROM generator import this too, so all three agree on one layout.
package piano_pkg;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned ARG_W  = 6;
    localparam int unsigned WORD_W = 16;

    // Event word: op[15:14] trk[13:12] note[11:6] arg[5:0]
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 14;
    localparam int unsigned TRK_MSB  = 13;
    localparam int unsigned TRK_LSB  = 12;
    localparam int unsigned NOTE_MSB = 11;
    localparam int unsigned NOTE_LSB = 6;
    localparam int unsigned ARG_MSB  = 5;
    localparam int unsigned ARG_LSB  = 0;

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_END  = 2'b10;
    localparam logic [1:0] OP_LOOP = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StWait  = 2'd3
    } state_t;

endpackage

// File: rtl/four_track_sequencer_if.sv
// Song ROM bus between the sequencer and a synchronous ROM.
//   rom_addr : registered word address (sequencer -> ROM)
//   rom_data : event word, valid the cycle after rom_addr changes (ROM -> sequencer)
interface four_track_sequencer_if #(
    parameter int unsigned ADDR_W = 8
) ();
    import piano_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/tick_timer.sv
// Two-level down-counter timing WAIT events. The unit counter spans TICK_DIV
// clock cycles, the step counter counts how many extra units remain. A load of
// `steps` = arg gives (arg+1)*TICK_DIV cycles of `run` before expire is seen.
//   clk_128hz, reset : clock, asynchronous active-high reset
//   clear            : force both counters to zero (abort)
//   load, steps      : start a new interval of (steps+1) units
//   run              : count while high
//   expire           : high in the last cycle of the interval while running
module tick_timer #(
    parameter int unsigned TICK_DIV = 8
) (
    input  logic                         clk_128hz,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         load,
    input  logic [piano_pkg::ARG_W-1:0]  steps,
    input  logic                         run,
    output logic                         expire
);
    import piano_pkg::*;

    localparam int unsigned UNIT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [UNIT_W-1:0] UNIT_RELOAD = UNIT_W'(TICK_DIV - 1);

    logic [UNIT_W-1:0] unit_q;
    logic [ARG_W-1:0]  step_q;

    always_ff @(posedge clk_128hz or posedge reset) begin
        if (reset) begin
            unit_q <= '0;
            step_q <= '0;
        end else if (clear) begin
            unit_q <= '0;
            step_q <= '0;
        end else if (load) begin
            unit_q <= UNIT_RELOAD;
            step_q <= steps;
        end else if (run) begin
            if (unit_q != '0) begin
                unit_q <= unit_q - UNIT_W'(1);
            end else if (step_q != '0) begin
                // The reload edge itself consumes the unit's last cycle.
                step_q <= step_q - ARG_W'(1);
                unit_q <= UNIT_RELOAD;
            end
        end
    end

    assign expire = run && (unit_q == '0) && (step_q == '0);

endmodule

// File: rtl/four_track_sequencer.sv
// Score-reading front end for the four-track player. Fetches packed event words
// from a synchronous song ROM, updates four note registers and times rests/holds
// in units of TICK_DIV clock cycles. One-shot or looping playback, abortable.
//   clk_128hz, reset          : clock, asynchronous active-high reset
//   start                     : begin playback at address 0 (honoured only when idle)
//   stop                      : abort playback, clears tracks, no done pulse
//   loop_en                   : LOOP restarts at 0 when set, ends playback when clear
//   rom                       : song ROM bus (registered address, 1-cycle read data)
//   track0..track3            : registered 6-bit note codes, 0 = rest
//   busy                      : high whenever not idle
//   done                      : one-cycle pulse when playback ends via END/LOOP
module four_track_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned TICK_DIV = 8
) (
    input  logic                          clk_128hz,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop_en,
    four_track_sequencer_if.master        rom,
    output logic [piano_pkg::NOTE_W-1:0]  track0,
    output logic [piano_pkg::NOTE_W-1:0]  track1,
    output logic [piano_pkg::NOTE_W-1:0]  track2,
    output logic [piano_pkg::NOTE_W-1:0]  track3,
    output logic                          busy,
    output logic                          done
);
    import piano_pkg::*;

    state_t              state_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [NOTE_W-1:0]   track_q [4];
    logic                done_q;

    logic [1:0]          op;
    logic [1:0]          trk;
    logic [NOTE_W-1:0]   note;
    logic [ARG_W-1:0]    arg;
    logic                abort;
    logic                timer_load;
    logic                timer_run;
    logic                timer_expire;

    assign op   = rom.rom_data[OP_MSB:OP_LSB];
    assign trk  = rom.rom_data[TRK_MSB:TRK_LSB];
    assign note = rom.rom_data[NOTE_MSB:NOTE_LSB];
    assign arg  = rom.rom_data[ARG_MSB:ARG_LSB];

    assign abort      = stop && (state_q != StIdle);
    assign timer_load = (state_q == StExec) && (op == OP_WAIT) && !stop;
    assign timer_run  = (state_q == StWait);

    tick_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_timer (
        .clk_128hz (clk_128hz),
        .reset     (reset),
        .clear     (abort),
        .load      (timer_load),
        .steps     (arg),
        .run       (timer_run),
        .expire    (timer_expire)
    );

    always_ff @(posedge clk_128hz or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < 4; i++) track_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q    <= StIdle;
                rom_addr_q <= '0;
                for (int i = 0; i < 4; i++) track_q[i] <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !stop) begin
                            state_q    <= StFetch;
                            rom_addr_q <= '0;
                        end
                    end
                    // Absorbs the ROM read latency; data is valid in StExec.
                    StFetch: state_q <= StExec;
                    StExec: begin
                        if (op == OP_SET) begin
                            track_q[trk] <= note;
                            rom_addr_q   <= rom_addr_q + ADDR_W'(1);
                            state_q      <= StFetch;
                        end else if (op == OP_WAIT) begin
                            rom_addr_q <= rom_addr_q + ADDR_W'(1);
                            state_q    <= StWait;
                        end else if (op == OP_LOOP && loop_en) begin
                            rom_addr_q <= '0;
                            state_q    <= StFetch;
                        end else begin
                            // END, or LOOP with looping disabled; address is kept.
                            for (int i = 0; i < 4; i++) track_q[i] <= '0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    StWait: begin
                        if (timer_expire) state_q <= StFetch;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign track0       = track_q[0];
    assign track1       = track_q[1];
    assign track2       = track_q[2];
    assign track3       = track_q[3];
    assign busy         = (state_q != StIdle);
    assign done         = done_q;

endmodule
